// File: rtl/hdmi_video_timing.sv
// Pixel-clock video timing generator: qualifies PLL lock, then produces raster
// counters and registered hsync/vsync/de/line_start/frame_start.
//
// state     | meaning
// WAIT_LOCK | idle, settle counter cleared, waiting for synchronized lock
// SETTLE    | lock seen, counting LOCK_SETTLE cycles of continuous lock
// RUN       | raster counters advancing, timing outputs live
module hdmi_video_timing #(
  parameter int   H_ACTIVE    = 1280,
  parameter int   H_FP        = 110,
  parameter int   H_SYNC      = 40,
  parameter int   H_BP        = 220,
  parameter int   V_ACTIVE    = 720,
  parameter int   V_FP        = 5,
  parameter int   V_SYNC      = 5,
  parameter int   V_BP        = 20,
  parameter logic SYNC_POL    = 1'b1,
  parameter int   LOCK_SETTLE = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lock,
  output logic        running,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int SW = $clog2(LOCK_SETTLE) + 1;

  localparam logic [11:0] H_ACT_W   = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_W   = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          lock_m_q, lock_s_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [11:0]   x_q, x_d;
  logic [10:0]   y_q, y_d;
  logic          run_d, de_d, hs_d, vs_d, ls_d, fs_d;
  logic          run_q, de_q, hs_q, vs_q, ls_q, fs_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    x_d      = 12'd0;
    y_d      = 11'd0;
    case (state_q)
      WAIT_LOCK: begin
        settle_d = '0;
        if (lock_s_q) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lock_s_q) begin
          state_d  = WAIT_LOCK;
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = RUN;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (x_q == H_LAST) begin
          x_d = 12'd0;
          y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
        end else begin
          x_d = x_q + 12'd1;
          y_d = y_q;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Decode from the next counter values so every output lines up with x/y.
    run_d = (state_d == RUN);
    de_d  = run_d && (x_d < H_ACT_W) && (y_d < V_ACT_W);
    hs_d  = (run_d && (x_d >= HS_START) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (run_d && (y_d >= VS_START) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    ls_d  = run_d && (x_d == 12'd0);
    fs_d  = ls_d && (y_d == 11'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
      state_q  <= WAIT_LOCK;
      settle_q <= '0;
      x_q      <= 12'd0;
      y_q      <= 11'd0;
      run_q    <= 1'b0;
      de_q     <= 1'b0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      lock_m_q <= lock;
      lock_s_q <= lock_m_q;
      state_q  <= state_d;
      settle_q <= settle_d;
      x_q      <= x_d;
      y_q      <= y_d;
      run_q    <= run_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign running     = run_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench for hdmi_video_timing: a small-raster instance and a default
// 720p instance with inverted sync polarity, checked against a scoreboard queue.
module tb_hdmi_video_timing;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic lock1 = 1'b1;
  logic lock2 = 1'b0;

  logic running1, hsync1, vsync1, de1, ls1, fs1;
  logic [11:0] x1;
  logic [10:0] y1;
  logic running2, hsync2, vsync2, de2, ls2, fs2;
  logic [11:0] x2;
  logic [10:0] y2;

  int n_vec = 0;
  int n_err = 0;
  logic [28:0] sb_q[$];

  always #5 clk = ~clk;

  hdmi_video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .LOCK_SETTLE(4)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .lock(lock1), .running(running1),
    .hsync(hsync1), .vsync(vsync1), .de(de1), .x(x1), .y(y1),
    .line_start(ls1), .frame_start(fs1)
  );

  hdmi_video_timing #(.SYNC_POL(1'b0)) u_hd (
    .clk(clk), .reset_n(reset_n), .lock(lock2), .running(running2),
    .hsync(hsync2), .vsync(vsync2), .de(de2), .x(x2), .y(y2),
    .line_start(ls2), .frame_start(fs2)
  );

  function automatic logic [28:0] vec1();
    return {running1, de1, hsync1, vsync1, ls1, fs1, x1, y1};
  endfunction

  function automatic logic [28:0] vec2();
    return {running2, de2, hsync2, vsync2, ls2, fs2, x2, y2};
  endfunction

  // Reference decode written straight from the raster definition.
  function automatic logic [28:0] model(int xx, int yy, int ha, int hf, int hw,
                                        int va, int vf, int vw, logic pol);
    logic e_de, e_hs, e_vs, e_ls, e_fs;
    e_de = (xx < ha) && (yy < va);
    e_hs = ((xx >= ha + hf) && (xx < ha + hf + hw)) ? pol : ~pol;
    e_vs = ((yy >= va + vf) && (yy < va + vf + vw)) ? pol : ~pol;
    e_ls = (xx == 0);
    e_fs = (xx == 0) && (yy == 0);
    return {1'b1, e_de, e_hs, e_vs, e_ls, e_fs, 12'(xx), 11'(yy)};
  endfunction

  function automatic logic [28:0] m_small(int xx, int yy);
    return model(xx, yy, 8, 2, 2, 4, 1, 1, 1'b1);
  endfunction

  function automatic logic [28:0] idle(logic pol);
    return {1'b0, 1'b0, ~pol, ~pol, 2'b00, 23'd0};
  endfunction

  task automatic chk(input string tag, input logic [28:0] obs, input logic [28:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic pop_chk(input string tag, input logic [28:0] obs);
    logic [28:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 29'd1, 29'd0);
    end else begin
      e = sb_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // Counts clock edges until running rises; the count is the startup latency.
  task automatic wait_run(input bit sel, input int exp_n, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? running2 : running1) && n < 2000);
    chk({tag, " latency"}, 29'(n), 29'(exp_n));
  endtask

  initial begin
    int last_fs;
    int xx, yy;

    // Reset state
    @(negedge clk);
    chk("reset small", vec1(), idle(1'b1));
    chk("reset hd", vec2(), idle(1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    // Startup with lock held from reset release
    wait_run(1'b0, 7, "startup");
    sb_q.push_back(m_small(0, 0));
    pop_chk("startup origin", vec1());

    // Two full frames, frame_start spacing
    last_fs = 0;
    for (int i = 1; i <= 196; i++) begin
      sb_q.push_back(m_small(i % 14, (i / 14) % 7));
      @(negedge clk);
      pop_chk("raster", vec1());
      if (fs1) begin
        chk("frame spacing", 29'(i - last_fs), 29'd98);
        last_fs = i;
      end
    end
    chk("frame count", 29'(last_fs), 29'd196);

    // Advance to x=5, y=2 then drop lock
    for (int i = 1; i <= 33; i++) begin
      sb_q.push_back(m_small(i % 14, (i / 14) % 7));
      @(negedge clk);
      pop_chk("pre-drop raster", vec1());
    end
    lock1 = 1'b0;
    sb_q.push_back(m_small(6, 2));
    sb_q.push_back(m_small(7, 2));
    sb_q.push_back(idle(1'b1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pop_chk("lock drop", vec1());
    end
    lock1 = 1'b1;
    wait_run(1'b0, 7, "relock");
    chk("relock origin", vec1(), m_small(0, 0));

    // Single-cycle lock glitch while settling at count 2
    lock1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle before glitch", vec1(), idle(1'b1));
    lock1 = 1'b1;
    repeat (3) @(negedge clk);
    lock1 = 1'b0;
    @(negedge clk);
    lock1 = 1'b1;
    wait_run(1'b0, 7, "post-glitch");
    chk("post-glitch origin", vec1(), m_small(0, 0));

    // Default 720p timing, active-low sync
    chk("hd idle", vec2(), idle(1'b0));
    lock2 = 1'b1;
    wait_run(1'b1, 1027, "hd startup");
    chk("hd origin", vec2(), model(0, 0, 1280, 110, 40, 720, 5, 5, 1'b0));
    for (int i = 1; i <= 1431; i++) begin
      sb_q.push_back(model(i, 0, 1280, 110, 40, 720, 5, 5, 1'b0));
      @(negedge clk);
      pop_chk("hd line", vec2());
    end

    // Asynchronous reset mid-run
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset small", vec1(), idle(1'b1));
    chk("async reset hd", vec2(), idle(1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    wait_run(1'b0, 7, "post-reset");
    xx = 0;
    yy = 0;
    chk("post-reset origin", vec1(), m_small(xx, yy));
    sb_q.push_back(m_small(1, 0));
    @(negedge clk);
    pop_chk("post-reset step", vec1());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
